// File: rtl/dramload_fsm_pkg.sv
// Shared types and widths for the scratchpad DRAM load path.
// Mirrors the load-side additions to sp_types_pkg.
package dramload_fsm_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BITS_PER_ROW = 128;
    localparam int unsigned ROW_IDX_W    = 2;
    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned BANK_W       = 2;

    // One queued load request: DRAM source address and destination row.
    typedef struct packed {
        logic [WORD_W-1:0]    addr;
        logic [ROW_IDX_W-1:0] row;
    } load_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        RETRY = 2'd3
    } dramload_state_t;

    // Bank index successor, wrapping 3 -> 0.
    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return b + BANK_W'(1);
    endfunction

endpackage

// File: rtl/dramload_fsm_if.sv
// Signal bundle between the load FSM, the request FIFOs, DRAM and the scratchpad.
// Optional macro DRAMLOAD_TIMEOUT_EN adds the load_retry strobe.
interface dramload_fsm_if;
    import dramload_fsm_pkg::*;

    logic                    loadFIFO0_empty;
    logic                    loadFIFO1_empty;
    logic                    loadFIFO2_empty;
    logic                    loadFIFO3_empty;
    load_req_t               loadFIFO0_rdata;
    load_req_t               loadFIFO1_rdata;
    load_req_t               loadFIFO2_rdata;
    load_req_t               loadFIFO3_rdata;
    logic                    loadFIFO0_REN;
    logic                    loadFIFO1_REN;
    logic                    loadFIFO2_REN;
    logic                    loadFIFO3_REN;
    logic                    sLoad;
    logic [WORD_W-1:0]       load_addr;
    logic                    sLoad_hit;
    logic [BITS_PER_ROW-1:0] load_data;
    logic                    sp_wen;
    logic [BANK_W-1:0]       sp_bank;
    logic [ROW_IDX_W-1:0]    sp_row;
    logic [BITS_PER_ROW-1:0] sp_wdata;
    logic                    load_complete;
    logic                    busy;
`ifdef DRAMLOAD_TIMEOUT_EN
    logic                    load_retry;
`endif

    // FSM side.
    modport master (
`ifdef DRAMLOAD_TIMEOUT_EN
        output load_retry,
`endif
        input  loadFIFO0_empty, loadFIFO1_empty, loadFIFO2_empty, loadFIFO3_empty,
        input  loadFIFO0_rdata, loadFIFO1_rdata, loadFIFO2_rdata, loadFIFO3_rdata,
        output loadFIFO0_REN, loadFIFO1_REN, loadFIFO2_REN, loadFIFO3_REN,
        output sLoad, load_addr,
        input  sLoad_hit, load_data,
        output sp_wen, sp_bank, sp_row, sp_wdata, load_complete, busy
    );

    // Environment side (FIFOs, DRAM, scratchpad).
    modport slave (
`ifdef DRAMLOAD_TIMEOUT_EN
        input  load_retry,
`endif
        output loadFIFO0_empty, loadFIFO1_empty, loadFIFO2_empty, loadFIFO3_empty,
        output loadFIFO0_rdata, loadFIFO1_rdata, loadFIFO2_rdata, loadFIFO3_rdata,
        input  loadFIFO0_REN, loadFIFO1_REN, loadFIFO2_REN, loadFIFO3_REN,
        input  sLoad, load_addr,
        output sLoad_hit, load_data,
        input  sp_wen, sp_bank, sp_row, sp_wdata, load_complete, busy
    );

    // Scratchpad write port view.
    modport sp (
        input sp_wen, sp_bank, sp_row, sp_wdata, load_complete
    );

endinterface

// File: rtl/dramload_fsm_rr_arbiter4.sv
// Four-way round-robin pick: first requester at or after ptr, wrapping 3 -> 0.
module dramload_fsm_rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;

    // Scan from ptr upward; keep the first hit.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dramload_fsm.sv
// Drains four per-bank load-request FIFOs round-robin, issues one DRAM load
// at a time and writes the returned row into the addressed scratchpad bank/row.
// Optional macro DRAMLOAD_TIMEOUT_EN: re-issue a load after TIMEOUT_CYCLES
// REQ cycles without a hit, signalled by a one-cycle load_retry pulse.
module dramload_fsm
    import dramload_fsm_pkg::*;
`ifdef DRAMLOAD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic           CLK,
    input  logic           nRST,
    dramload_fsm_if.master bus
);

    dramload_state_t         state_q, state_d;
    logic [BANK_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [WORD_W-1:0]       addr_q, addr_d;
    logic [ROW_IDX_W-1:0]    row_q, row_d;
    logic [BITS_PER_ROW-1:0] data_q, data_d;

    logic [3:0]              fifo_empty;
    load_req_t               fifo_head [NUM_BANKS];
    logic [3:0]              ren_c;
    logic                    grant_valid;
    logic [BANK_W-1:0]       grant_idx;
    logic                    sload_c;
    logic                    wen_c;

`ifdef DRAMLOAD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0]            wait_q, wait_d;
`endif

    assign fifo_empty   = {bus.loadFIFO3_empty, bus.loadFIFO2_empty,
                           bus.loadFIFO1_empty, bus.loadFIFO0_empty};
    assign fifo_head[0] = bus.loadFIFO0_rdata;
    assign fifo_head[1] = bus.loadFIFO1_rdata;
    assign fifo_head[2] = bus.loadFIFO2_rdata;
    assign fifo_head[3] = bus.loadFIFO3_rdata;

    dramload_fsm_rr_arbiter4 u_rr_arbiter4 (
        .req         (~fifo_empty),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            data_q   <= '0;
`ifdef DRAMLOAD_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            row_q    <= row_d;
            data_q   <= data_d;
`ifdef DRAMLOAD_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    // Next-state, request capture and FIFO pop.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        row_d    = row_q;
        data_d   = data_q;
        ren_c    = '0;
`ifdef DRAMLOAD_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    ren_c[grant_idx] = 1'b1;
                    bank_d           = grant_idx;
                    addr_d           = fifo_head[grant_idx].addr;
                    row_d            = fifo_head[grant_idx].row;
                    state_d          = REQ;
`ifdef DRAMLOAD_TIMEOUT_EN
                    wait_d           = '0;
`endif
                end
            end
            REQ: begin
                if (bus.sLoad_hit) begin
                    data_d  = bus.load_data;
                    state_d = WRITE;
                end
`ifdef DRAMLOAD_TIMEOUT_EN
                else if (wait_q + 16'd1 == TIMEOUT_LIM) begin
                    wait_d  = '0;
                    state_d = RETRY;
                end else begin
                    wait_d  = wait_q + 16'd1;
                end
`endif
            end
            WRITE: begin
                rr_ptr_d = next_bank(bank_q);
                state_d  = IDLE;
            end
            RETRY: begin
                state_d = REQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sload_c = (state_q == REQ);
    assign wen_c   = (state_q == WRITE);

    // Pops are gated by nRST so a FIFO is never drained while reset is held.
    assign bus.loadFIFO0_REN = ren_c[0] & nRST;
    assign bus.loadFIFO1_REN = ren_c[1] & nRST;
    assign bus.loadFIFO2_REN = ren_c[2] & nRST;
    assign bus.loadFIFO3_REN = ren_c[3] & nRST;

    // Payloads are forced to zero whenever their strobe is low.
    assign bus.sLoad         = sload_c;
    assign bus.load_addr     = sload_c ? addr_q : '0;
    assign bus.sp_wen        = wen_c;
    assign bus.load_complete = wen_c;
    assign bus.sp_bank       = wen_c ? bank_q : '0;
    assign bus.sp_row        = wen_c ? row_q : '0;
    assign bus.sp_wdata      = wen_c ? data_q : '0;
    assign bus.busy          = (state_q != IDLE);
`ifdef DRAMLOAD_TIMEOUT_EN
    assign bus.load_retry    = (state_q == RETRY);
`endif

endmodule

// File: doc/dramload_fsm.md
Name: dramload_fsm

Overview:
- Load-direction counterpart of the scratchpad DRAM store path.
- Drains four per-bank load-request FIFOs in round-robin order and issues one DRAM load per request (sLoad/load_addr, completed by sLoad_hit with load_data).
- Writes each returned row into the addressed scratchpad bank and row.
- Sits between the scratchpad load-request FIFOs and the DRAM/memory arbiter; one request is in flight at a time.

Parameters:
- WORD_W, 32, DRAM address width (matches sp_types_pkg).
- BITS_PER_ROW, 128, scratchpad row / DRAM load data width (matches sp_types_pkg).
- ROW_IDX_W, 2, scratchpad row index width.
- TIMEOUT_CYCLES, 64, cycles in REQ with no hit before re-issue (only used with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- loadFIFO0_empty..loadFIFO3_empty  in  1 each  request FIFO n empty.
- loadFIFO0_rdata..loadFIFO3_rdata  in  load_req_t each  head entry; show-ahead, valid whenever !empty.
- loadFIFO0_REN..loadFIFO3_REN  out  1 each  pop head of FIFO n.
- sLoad  out  1  DRAM load request, level.
- load_addr  out  WORD_W  DRAM address for sLoad.
- sLoad_hit  in  1  DRAM load done; load_data valid this cycle.
- load_data  in  BITS_PER_ROW  returned row.
- sp_wen  out  1  scratchpad write strobe.
- sp_bank  out  2  destination bank = source FIFO index.
- sp_row  out  ROW_IDX_W  destination row.
- sp_wdata  out  BITS_PER_ROW  row data.
- load_complete  out  1  one-cycle pulse, coincident with sp_wen.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, nRST=0):
  - State = IDLE, rr_ptr = 0, all registers cleared.
  - All outputs 0.
  - Reset mid-request abandons the request: no scratchpad write, and the popped FIFO entry is lost.
- IDLE:
  - Scan banks starting at rr_ptr, wrapping 3->0, for the first one with !empty.
  - If found, pulse that FIFO's REN for exactly this cycle and latch its rdata (addr, row) plus the bank index, then go to REQ.
  - Only one REN is ever high in a cycle.
  - If all FIFOs are empty, stay in IDLE.
- REQ:
  - sLoad = 1 and load_addr = latched addr, both held stable until hit.
  - When sLoad_hit = 1, register load_data and go to WRITE; sLoad falls on the next cycle.
  - sLoad_hit seen outside REQ is ignored.
- WRITE (exactly 1 cycle):
  - sp_wen = 1 and load_complete = 1.
  - sp_bank, sp_row and sp_wdata come from the registers.
  - rr_ptr <= bank+1 (mod 4), then go to IDLE.
- Latency and throughput:
  - Pop to sp_wen is at least 2 cycles (pop in IDLE, hit in the first REQ cycle, WRITE next).
  - Best-case throughput is one request per 3 cycles.
- Fairness: a bank just serviced has lowest priority next time.
  - All four FIFOs continuously non-empty are serviced in order 0,1,2,3,0,...
- Outputs:
  - load_addr, sp_row, sp_bank and sp_wdata are 0 whenever their strobe is low.
  - busy = (state != IDLE).

Optional Feature:
- Macro: DRAMLOAD_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter is cleared on entry to REQ and increments every REQ cycle without a hit.
  - When it reaches TIMEOUT_CYCLES, drop sLoad for 1 cycle (RETRY state), pulse the extra output load_retry (1 bit), clear the counter and return to REQ re-issuing the same address.
  - A hit arriving during the RETRY cycle is ignored.
- When undefined: there is no counter and no load_retry port; REQ waits indefinitely.

Decomposition:
- sp_types_pkg additions:
  - load_req_t packed struct {addr [WORD_W-1:0], row [ROW_IDX_W-1:0]}.
  - dramload_state_t enum {IDLE, REQ, WRITE, RETRY}.
  - ROW_IDX_W constant.
- New dramload_FSM_if interface with an sp modport.
- Sub-module rr_arbiter4: inputs req[3:0] and ptr[1:0]; outputs grant_valid and grant_idx[1:0]; combinational.

Test Plan:
- Reset: hold nRST=0 with FIFO0 non-empty -> all outputs 0, no REN; release -> REN0 pulses on the first cycle.
- Single load: FIFO2 = {addr=0x1000, row=3}, hit 5 cycles after sLoad rises, load_data=0xA5..A5 -> sLoad high for 5 cycles with load_addr=0x1000, then sp_wen=1, sp_bank=2, sp_row=3, sp_wdata=0xA5..A5 and load_complete for 1 cycle.
- Round-robin: all 4 FIFOs hold 2 entries each, hit immediate -> REN order 0,1,2,3,0,1,2,3, one request per 3 cycles, no cycle with two REN high.
- Pointer wrap: FIFO3 serviced, then only FIFO0 and FIFO3 non-empty -> FIFO0 served next.
- Reset mid-request: assert nRST low while in REQ -> sLoad drops immediately; after release, no sp_wen for the abandoned request.
- With DRAMLOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no hit -> sLoad low for 1 cycle every 9 cycles with the same load_addr and a load_retry pulse; a later hit completes normally.
